// File: rtl/ram_512_64_arb.sv
// Arbitrating controller for a 512x64 simple dual-port RAM: two readers, one writer, clear sequencer.
// Define RAM_512_64_ARB_RR_EN for round-robin read arbitration; otherwise A has fixed priority over B.
module ram_512_64_arb #(
  parameter int            AW         = 9,
  parameter int            DW         = 64,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_gnt,
  input  logic          clr_req,
  output logic          busy,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rd,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wr,
  output logic          ram_we
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_ptr, clr_ptr_next;
  logic          run;

  // Grants depend on rst directly so nothing reaches the RAM while reset is held.
  assign run = rst && (state == RUN);

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= INIT;
      clr_ptr  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      state    <= state_next;
      clr_ptr  <= clr_ptr_next;
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt;
    end
  end

`ifdef RAM_512_64_ARB_RR_EN
  logic rr_last;  // 1: B won the most recent granted read

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_last <= 1'b1;
    end else if (a_gnt) begin
      rr_last <= 1'b0;
    end else if (b_gnt) begin
      rr_last <= 1'b1;
    end
  end

  assign a_gnt = run && a_req && (!b_req || rr_last);
`else
  assign a_gnt = run && a_req;
`endif
  assign b_gnt = run && b_req && !a_gnt;

  assign ram_re    = a_gnt || b_gnt;
  assign ram_raddr = b_gnt ? b_addr : a_addr;
  assign a_rdata   = ram_rd;
  assign b_rdata   = ram_rd;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    busy         = 1'b1;
    w_gnt        = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = w_addr;
    ram_wr       = w_data;
    if (rst) begin
      case (state)
        INIT: begin
          ram_we       = 1'b1;
          ram_waddr    = clr_ptr;
          ram_wr       = INIT_VALUE;
          clr_ptr_next = clr_ptr + AW'(1);
          if (clr_ptr == '1) begin
            state_next   = RUN;
            clr_ptr_next = '0;
          end
        end
        RUN: begin
          busy   = 1'b0;
          w_gnt  = w_req;
          ram_we = w_req;
          if (clr_req) begin
            state_next   = INIT;
            clr_ptr_next = '0;
          end
        end
        default: state_next = INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_512_64_arb.sv
// Directed bench for ram_512_64_arb with a behavioural 512x64 RAM (1-cycle read, write-to-read forwarding).
module tb_ram_512_64_arb;

  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req, w_req, clr_req;
  logic [AW-1:0] a_addr, b_addr, w_addr;
  logic [DW-1:0] w_data;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, w_gnt, busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic          ram_re, ram_we;
  logic [DW-1:0] ram_rd, ram_wr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_512_64_arb #(.AW(AW), .DW(DW), .INIT_VALUE(64'h0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_gnt(w_gnt),
    .clr_req(clr_req), .busy(busy),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rd(ram_rd),
    .ram_waddr(ram_waddr), .ram_wr(ram_wr), .ram_we(ram_we)
  );

  // Behavioural RAM, pre-filled with a non-zero pattern so the clear is observable.
  logic [DW-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    ram_rd = '0;
  end
  always @(posedge clk) begin
    if (ram_re) ram_rd <= (ram_we && ram_waddr == ram_raddr) ? ram_wr : mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_a [4];

  initial begin
    rst = 1'b0; clr_req = 1'b0;
    a_req = 1'b1; a_addr = 9'd300;
    b_req = 1'b0; b_addr = '0;
    w_req = 1'b0; w_addr = '0; w_data = '0;

    // Reset held for two edges: nothing granted, nothing written.
    tick(); tick(); settle();
    check("rst_busy",     64'(busy),     64'd1);
    check("rst_ram_we",   64'(ram_we),   64'd0);
    check("rst_ram_re",   64'(ram_re),   64'd0);
    check("rst_a_gnt",    64'(a_gnt),    64'd0);
    check("rst_a_rvalid", 64'(a_rvalid), 64'd0);

    // Clear: 512 consecutive writes of 0 to addresses 0..511; a stray clr_req must not extend it.
    #1 rst = 1'b1;
    for (int i = 0; i < 512; i++) begin
      settle();
      check("init_we",    64'(ram_we),    64'd1);
      check("init_waddr", 64'(ram_waddr), 64'(i));
      check("init_wr",    ram_wr,         64'h0);
      check("init_busy",  64'(busy),      64'd1);
      check("init_a_gnt", 64'(a_gnt),     64'd0);
      tick();
      clr_req = (i == 100);
    end
    clr_req = 1'b0;
    settle();
    check("run_busy",   64'(busy),      64'd0);
    check("run_a_gnt",  64'(a_gnt),     64'd1);
    check("run_raddr",  64'(ram_raddr), 64'd300);
    tick();
    a_req = 1'b0;
    settle();
    check("rd300_rvalid", 64'(a_rvalid), 64'd1);
    check("rd300_rdata",  a_rdata,       64'h0);

    // Write then read back through A.
    tick();
    w_req = 1'b1; w_addr = 9'd5; w_data = 64'hDEADBEEF_00000005;
    settle();
    check("wr5_gnt",   64'(w_gnt),     64'd1);
    check("wr5_we",    64'(ram_we),    64'd1);
    check("wr5_waddr", 64'(ram_waddr), 64'd5);
    check("wr5_wr",    ram_wr,         64'hDEADBEEF_00000005);
    tick();
    w_req = 1'b0; a_req = 1'b1; a_addr = 9'd5;
    settle();
    check("rd5_a_gnt", 64'(a_gnt),     64'd1);
    check("rd5_b_gnt", 64'(b_gnt),     64'd0);
    check("rd5_re",    64'(ram_re),    64'd1);
    check("rd5_raddr", 64'(ram_raddr), 64'd5);
    tick();
    a_req = 1'b0;
    settle();
    check("rd5_a_rvalid", 64'(a_rvalid), 64'd1);
    check("rd5_a_rdata",  a_rdata,       64'hDEADBEEF_00000005);
    check("rd5_b_rvalid", 64'(b_rvalid), 64'd0);

    // Same-cycle write and B read of addr 9: forwarded data; B is now the last winner.
    tick();
    w_req = 1'b1; w_addr = 9'd9; w_data = 64'h1234;
    b_req = 1'b1; b_addr = 9'd9;
    settle();
    check("fwd_b_gnt", 64'(b_gnt),     64'd1);
    check("fwd_a_gnt", 64'(a_gnt),     64'd0);
    check("fwd_raddr", 64'(ram_raddr), 64'd9);
    tick();
    w_req = 1'b0; b_req = 1'b0;
    settle();
    check("fwd_b_rvalid", 64'(b_rvalid), 64'd1);
    check("fwd_b_rdata",  b_rdata,       64'h1234);
    check("fwd_a_rvalid", 64'(a_rvalid), 64'd0);

    // Contention for four cycles.
`ifdef RAM_512_64_ARB_RR_EN
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    a_addr = 9'd10; b_addr = 9'd20;
    for (int k = 0; k < 4; k++) begin
      tick();
      a_req = 1'b1; b_req = 1'b1;
      settle();
      check("arb_a_gnt", 64'(a_gnt),     64'(exp_a[k]));
      check("arb_b_gnt", 64'(b_gnt),     64'(!exp_a[k]));
      check("arb_raddr", 64'(ram_raddr), exp_a[k] ? 64'd10 : 64'd20);
      if (k > 0) begin
        check("arb_a_rvalid", 64'(a_rvalid), 64'(exp_a[k-1]));
        check("arb_b_rvalid", 64'(b_rvalid), 64'(!exp_a[k-1]));
      end
    end
    tick();
    a_req = 1'b0; b_req = 1'b0;
    settle();
    check("arb_last_a_rvalid", 64'(a_rvalid), 64'(exp_a[3]));
    check("arb_last_b_rvalid", 64'(b_rvalid), 64'(!exp_a[3]));
    check("arb_last_rdata",    a_rdata,       64'h0);

    // Clear requested in RUN alongside a read of addr 7.
    tick();
    w_req = 1'b1; w_addr = 9'd7; w_data = 64'hAA;
    settle();
    check("wr7_gnt", 64'(w_gnt), 64'd1);
    tick();
    w_req = 1'b0; clr_req = 1'b1; a_req = 1'b1; a_addr = 9'd7;
    settle();
    check("clr_a_gnt", 64'(a_gnt), 64'd1);
    check("clr_busy",  64'(busy),  64'd0);
    tick();
    clr_req = 1'b0; a_req = 1'b0;
    for (int i = 0; i < 512; i++) begin
      settle();
      if (i == 0) begin
        check("clr_a_rvalid", 64'(a_rvalid), 64'd1);
        check("clr_a_rdata",  a_rdata,       64'hAA);
      end
      check("clr2_busy",  64'(busy),      64'd1);
      check("clr2_waddr", 64'(ram_waddr), 64'(i));
      tick();
      clr_req = (i == 50);
    end
    clr_req = 1'b0; a_req = 1'b1; a_addr = 9'd7;
    settle();
    check("clr2_done_busy", 64'(busy),  64'd0);
    check("rd7_a_gnt",      64'(a_gnt), 64'd1);
    tick();
    a_req = 1'b0;
    settle();
    check("rd7_a_rvalid", 64'(a_rvalid), 64'd1);
    check("rd7_a_rdata",  a_rdata,       64'h0);

    // Reset arriving right after a grant drops the response and restarts the clear.
    tick();
    a_req = 1'b1; a_addr = 9'd7;
    settle();
    check("mid_a_gnt", 64'(a_gnt), 64'd1);
    #1 rst = 1'b0;
    tick();
    a_req = 1'b0;
    settle();
    check("mid_a_rvalid", 64'(a_rvalid), 64'd0);
    check("mid_busy",     64'(busy),     64'd1);
    check("mid_ram_we",   64'(ram_we),   64'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("restart_we",    64'(ram_we),    64'd1);
      check("restart_waddr", 64'(ram_waddr), 64'(i));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
